// File: rtl/load_align_if.sv
// Load unit bus bundle: request, data-memory port and result channels.
// slave = load unit side, master = pipeline/memory side.
interface load_align_if #(
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_width;
  logic [RD_W-1:0]   req_rd;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_resp_valid;
  logic [63:0]       mem_rdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [63:0]       ld_data;
  logic [RD_W-1:0]   ld_rd;
  logic              ld_fault;

  modport slave (
    input  req_valid, req_addr, req_width, req_rd,
    output req_ready,
    output mem_req_valid, mem_addr,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ld_valid, ld_data, ld_rd, ld_fault,
    input  ld_ready
  );

  modport master (
    output req_valid, req_addr, req_width, req_rd,
    input  req_ready,
    input  mem_req_valid, mem_addr,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ld_valid, ld_data, ld_rd, ld_fault,
    output ld_ready
  );
endinterface

// File: rtl/load_align_unit.sv
// Load lane extraction: aligned dword read, lane select, sign/zero extend.
// Define MISALIGN_TRAP_EN to fault misaligned lh/lw/ld instead of reading.
module load_align_unit #(
  parameter int ADDR_W = 64,
  parameter int RD_W   = 5
) (
  input  logic      clk,
  input  logic      rstn,
  load_align_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        width_q;
  logic [RD_W-1:0]   rd_q;
  logic [63:0]       data_q;
  logic              fault_q;
  logic              accept;
  logic              mis;

  logic [2:0]  o;
  logic        sz_d, sz_w, sz_h, sz_b, sgn;
  logic [31:0] w32;
  logic [15:0] h16;
  logic [7:0]  b8;
  logic [63:0] ext;

  assign accept = (state_q == IDLE) & bus.req_valid;

`ifdef MISALIGN_TRAP_EN
  logic [2:0] a_lo;
  assign a_lo = bus.req_addr[2:0];

  always_comb begin
    mis = 1'b0;
    unique case (bus.req_width)
      3'b001:         mis = |a_lo;
      3'b010, 3'b101: mis = |a_lo[1:0];
      3'b011, 3'b110: mis = a_lo[0];
      default:        mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid)
              state_d = (bus.req_width == 3'b000 || mis)
                        ? RESP : REQ;
      REQ:  if (bus.mem_req_ready)  state_d = WAIT;
      WAIT: if (bus.mem_resp_valid) state_d = RESP;
      RESP: if (bus.ld_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign o    = addr_q[2:0];
  assign sz_d = (width_q == 3'b001);
  assign sz_w = (width_q == 3'b010) | (width_q == 3'b101);
  assign sz_h = (width_q == 3'b011) | (width_q == 3'b110);
  assign sz_b = (width_q == 3'b100) | (width_q == 3'b111);
  assign sgn  = (width_q == 3'b010) | (width_q == 3'b011)
              | (width_q == 3'b100);

  assign w32 = o[2] ? bus.mem_rdata[63:32]
                    : bus.mem_rdata[31:0];
  assign h16 = bus.mem_rdata[{o[2:1], 4'b0000} +: 16];
  assign b8  = bus.mem_rdata[{o, 3'b000} +: 8];

  always_comb begin
    ext = '0;
    unique case (1'b1)
      sz_d:    ext = bus.mem_rdata;
      sz_w:    ext = {{32{sgn & w32[31]}}, w32};
      sz_h:    ext = {{48{sgn & h16[15]}}, h16};
      sz_b:    ext = {{56{sgn & b8[7]}}, b8};
      default: ext = '0;
    endcase
  end

  // data_q is cleared on accept so width 000 and faults report zero
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q  <= '0;
      width_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        width_q <= bus.req_width;
        rd_q    <= bus.req_rd;
        data_q  <= '0;
        fault_q <= mis;
      end
      if (state_q == WAIT && bus.mem_resp_valid)
        data_q <= ext;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.ld_valid      = (state_q == RESP);
  assign bus.ld_data       = data_q;
  assign bus.ld_rd         = rd_q;
  assign bus.ld_fault      = fault_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: random loads vs a byte-level model.
// Memory responder and result monitor run independently of stimulus.
module tb_load_align_unit;
  localparam int ADDR_W = 64;
  localparam int RD_W   = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  load_align_if #(.ADDR_W(ADDR_W), .RD_W(RD_W)) bus ();

  load_align_unit #(.ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [63:0]     data;
    logic [RD_W-1:0] rd;
    logic            fault;
    logic            mem;
  } exp_t;

  exp_t        ld_q[$];
  logic [63:0] maddr_q[$];
  logic [63:0] mem [16];

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 0;
  bit bp_mode = 0;
  bit stray_en = 1;
  int resp_delay = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out", name);
  endtask

  // byte-level reference: pick n bytes at the n-aligned offset, then extend
  function automatic exp_t model(input logic [63:0] a, input logic [2:0] w,
                                 input logic [RD_W-1:0] rd);
    exp_t e;
    int n;
    bit sg;
    int o;
    logic [63:0] mask;
    logic [63:0] word;
    e.rd = rd; e.data = '0; e.fault = 1'b0; e.mem = 1'b0;
    case (w)
      3'd1: begin n = 8; sg = 0; end
      3'd2: begin n = 4; sg = 1; end
      3'd3: begin n = 2; sg = 1; end
      3'd4: begin n = 1; sg = 1; end
      3'd5: begin n = 4; sg = 0; end
      3'd6: begin n = 2; sg = 0; end
      3'd7: begin n = 1; sg = 0; end
      default: begin n = 0; sg = 0; end
    endcase
    if (n == 0) return e;
    o = int'(a[2:0]);
`ifdef MISALIGN_TRAP_EN
    if (o % n != 0) begin
      e.fault = 1'b1;
      return e;
    end
`endif
    o = o - (o % n);
    word = mem[a[6:3]];
    mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    e.data = (word >> (8 * o)) & mask;
    if (sg && e.data[8 * n - 1]) e.data = e.data | ~mask;
    e.mem = 1'b1;
    return e;
  endfunction

  // memory responder: drives mem_req_ready / mem_resp_valid on negedges
  initial begin
    int pend;
    int bpc;
    logic [63:0] pdata;
    bit rdy;
    pend = 0; bpc = 0; pdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata = pdata;
        end
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
      end
      if (bp_mode) begin
        rdy = (bus.mem_req_valid === 1'b1) && bpc >= 3;
        bpc = (bus.mem_req_valid === 1'b1) ? bpc + 1 : 0;
      end else begin
        rdy = $urandom_range(0, 3) != 0;
      end
      bus.mem_req_ready = rdy;
      if (mon_en && bus.mem_req_valid === 1'b1) begin
        check("req_ready_busy_mem", 64'(bus.req_ready), 64'd0);
        if (maddr_q.size() == 0) begin
          n_total++;
          $display("FAIL mem_unexpected: mem_req_valid=1 addr %h, required no request",
                   bus.mem_addr);
        end else begin
          check("mem_addr", bus.mem_addr, maddr_q[0]);
        end
        if (rdy) begin
          if (maddr_q.size() != 0) void'(maddr_q.pop_front());
          pend  = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 3));
          pdata = mem[bus.mem_addr[6:3]];
        end
      end
    end
  end

  // result monitor: drives ld_ready, compares every valid cycle to queue head
  initial begin
    int bpl;
    bit rdy;
    bpl = 0;
    forever begin
      @(negedge clk);
      if (bp_mode) begin
        rdy = !(bus.ld_valid === 1'b1 && bpl < 4);
        bpl = (bus.ld_valid === 1'b1) ? bpl + 1 : 0;
      end else begin
        rdy = $urandom_range(0, 3) != 0;
      end
      bus.ld_ready = rdy;
      if (mon_en && bus.ld_valid === 1'b1) begin
        check("req_ready_busy_resp", 64'(bus.req_ready), 64'd0);
        if (ld_q.size() == 0) begin
          n_total++;
          $display("FAIL ld_unexpected: ld_valid=1 data %h, required no result",
                   bus.ld_data);
        end else begin
          check("ld_data",  bus.ld_data, ld_q[0].data);
          check("ld_rd",    64'(bus.ld_rd), 64'(ld_q[0].rd));
          check("ld_fault", 64'(bus.ld_fault), 64'(ld_q[0].fault));
          if (rdy) void'(ld_q.pop_front());
        end
      end
    end
  end

  task automatic rst_check();
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_ld_valid", 64'(bus.ld_valid), 64'd0);
    check("rst_ld_fault", 64'(bus.ld_fault), 64'd0);
    check("rst_ld_data", bus.ld_data, 64'd0);
    check("rst_ld_rd", 64'(bus.ld_rd), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
  endtask

  task automatic issue(input logic [63:0] a, input logic [2:0] w,
                       input logic [RD_W-1:0] rd, input exp_t e,
                       input bit expect_ld);
    bit ok;
    if (e.mem) maddr_q.push_back({a[63:3], 3'b000});
    if (expect_ld) ld_q.push_back(e);
    bus.req_addr  = a;
    bus.req_width = w;
    bus.req_rd    = rd;
    bus.req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1;
    end
    if (!ok) timeout("accept");
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = {$urandom, $urandom};
    bus.req_width = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (ld_q.size() == 0 && maddr_q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    timeout("drain");
    ld_q.delete();
    maddr_q.delete();
  endtask

  task automatic dir(input logic [63:0] a, input logic [2:0] w,
                     input logic [RD_W-1:0] rd, input logic [63:0] d,
                     input bit f, input bit m);
    exp_t e;
    e.data = d; e.rd = rd; e.fault = f; e.mem = m;
    issue(a, w, rd, e, 1'b1);
    drain();
  endtask

  initial begin
    exp_t e;
    logic [63:0] a;
    logic [2:0] w;
    logic [RD_W-1:0] rd;
    bit ok;
    bus.req_valid = 0; bus.req_addr = '0; bus.req_width = '0; bus.req_rd = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    bus.ld_ready = 0;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};

    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_check();
    rstn = 1'b1;
    mon_en = 1'b1;

    mem[0] = 64'h0000_0000_8000_0000;
    dir(64'h1003, 3'd4, 5'd1, 64'hFFFF_FFFF_FFFF_FF80, 0, 1);
    dir(64'h1003, 3'd7, 5'd2, 64'h0000_0000_0000_0080, 0, 1);
    mem[0] = 64'h8000_0000_1234_5678;
    dir(64'h2004, 3'd2, 5'd3, 64'hFFFF_FFFF_8000_0000, 0, 1);
    dir(64'h2004, 3'd5, 5'd4, 64'h0000_0000_8000_0000, 0, 1);
    dir(64'h2000, 3'd2, 5'd5, 64'h0000_0000_1234_5678, 0, 1);
    mem[0] = 64'hBEEF_0000_0000_0000;
    dir(64'h3006, 3'd3, 5'd6, 64'hFFFF_FFFF_FFFF_BEEF, 0, 1);
    dir(64'h3006, 3'd6, 5'd7, 64'h0000_0000_0000_BEEF, 0, 1);
    dir(64'h3000, 3'd1, 5'd8, 64'hBEEF_0000_0000_0000, 0, 1);
    dir(64'h3006, 3'd0, 5'd9, 64'h0, 0, 0);
    mem[0] = 64'h1122_3344_5566_7788;
`ifdef MISALIGN_TRAP_EN
    dir(64'h1002, 3'd2, 5'd10, 64'h0, 1, 0);
`else
    dir(64'h1002, 3'd2, 5'd10, 64'h0000_0000_5566_7788, 0, 1);
`endif

    bp_mode = 1'b1;
    stray_en = 1'b0;
    e = model(64'h4008, 3'd2, 5'd13);
    issue(64'h4008, 3'd2, 5'd13, e, 1'b1);
    drain();
    bp_mode = 1'b0;

    resp_delay = 4;
    e = model(64'h5010, 3'd1, 5'd11);
    issue(64'h5010, 3'd1, 5'd11, e, 1'b0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (maddr_q.size() == 0) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) timeout("reset_wait_accept");
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rst_check();
    repeat (8) @(posedge clk);
    #1;
    rst_check();
    resp_delay = 0;
    stray_en = 1'b1;
    e = model(64'h5010, 3'd1, 5'd12);
    issue(64'h5010, 3'd1, 5'd12, e, 1'b1);
    drain();

    for (int k = 0; k < 300; k++) begin
      a  = {$urandom, $urandom};
      w  = 3'($urandom_range(0, 7));
      rd = RD_W'($urandom);
      e  = model(a, w, rd);
      issue(a, w, rd, e, 1'b1);
      drain();
      if ($urandom_range(0, 3) == 0)
        mem[$urandom_range(0, 15)] = {$urandom, $urandom};
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
